// File: rtl/countdown_pkg.sv
// Shared state encoding, mm:ss limits and load saturation helpers for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StRing
  } state_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [6:0] MIN_MAX = 7'd99;

  function automatic logic [6:0] sat_min(input logic [6:0] v);
    return (v > MIN_MAX) ? MIN_MAX : v;
  endfunction

  function automatic logic [5:0] sat_sec(input logic [5:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; tick is high for the one cycle in which the count wraps.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count_q;

  assign tick = en && (count_q == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with load/start/pause/clear and a ring level at 00:00.
// Optional RING_TIMEOUT_EN: ring self-clears after RING_CYCLES, counted on the shared prescaler.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 5_000_000,
  parameter int unsigned RING_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       ring_ack,
  output logic [6:0] remain_min,
  output logic [5:0] remain_sec,
  output logic       running,
  output logic       ring
);

  state_e     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       running_q, ring_q;
  logic       tick, presc_en, presc_clr, load_ok, remain_zero;

`ifdef RING_TIMEOUT_EN
  // Timeout is counted in whole prescaler wraps, so RING_CYCLES is a multiple of TICK_DIV.
  localparam int unsigned RingTicks = RING_CYCLES / TICK_DIV;
  localparam int unsigned RtW       = $clog2(RingTicks + 1);
  logic [RtW-1:0] ring_ticks_q, ring_ticks_d;
  assign presc_en = (state_q == StRun) || (state_q == StRing);
`else
  assign presc_en = (state_q == StRun);
`endif

  assign remain_zero = (min_q == '0) && (sec_q == '0);
  // Entering IDLE or accepting a load restarts the 1 s phase from zero.
  assign presc_clr   = load_ok || (state_d == StIdle);

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (presc_en),
    .clr    (presc_clr),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    load_ok = 1'b0;
`ifdef RING_TIMEOUT_EN
    ring_ticks_d = '0;
`endif
    if (clear) begin
      state_d = StIdle;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StPaused: begin
          if (!ring_ack && !pause) begin
            if (start) begin
              if (!remain_zero) state_d = StRun;
            end else if (load) begin
              load_ok = 1'b1;
              min_d   = sat_min(load_min);
              sec_d   = sat_sec(load_sec);
            end
          end
        end
        StRun: begin
          if (tick && !remain_zero) begin
            if (sec_q != '0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              sec_d = SEC_MAX;
              min_d = min_q - 7'd1;
            end
            // Reaching zero wins over a coincident pause.
            if ((min_d == '0) && (sec_d == '0)) state_d = StRing;
            else if (pause)                     state_d = StPaused;
          end else if (pause) begin
            state_d = StPaused;
          end
        end
        StRing: begin
          if (ring_ack) begin
            state_d = StIdle;
          end
`ifdef RING_TIMEOUT_EN
          else if (tick) begin
            if (ring_ticks_q == RtW'(RingTicks - 1)) state_d = StIdle;
            else ring_ticks_d = ring_ticks_q + 1'b1;
          end else begin
            ring_ticks_d = ring_ticks_q;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      ring_q    <= 1'b0;
`ifdef RING_TIMEOUT_EN
      ring_ticks_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= (state_d == StRun);
      ring_q    <= (state_d == StRing);
`ifdef RING_TIMEOUT_EN
      ring_ticks_q <= ring_ticks_d;
`endif
    end
  end

  assign remain_min = min_q;
  assign remain_sec = sec_q;
  assign running    = running_q;
  assign ring       = ring_q;

endmodule
